// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its neighbours.
//   JUMP_*    : 2-bit jump-select encodings, matching the ID-stage decoder
//   NOP_INSTR : bubble encoding (sll $0,$0,0)
//   RESET_PC  : fetch address loaded on reset
package if_stage_pkg;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_J    = 2'b01;
    localparam logic [1:0] JUMP_JR   = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;

    // Pseudo-direct J/JAL target: top nibble of the delay-free PC+4 of the
    // jump itself, then the 26-bit instruction index shifted to a word address.
    function automatic logic [31:0] j_target(input logic [31:0] pc_plus4,
                                             input logic [31:0] instr);
        return {pc_plus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_npc_sel.sv
// Next-PC selection for the fetch stage (purely combinational).
// Ports:
//   pc            in  current fetch PC
//   id_valid      in  IF/ID holds a real instruction (qualifies redirects)
//   id_instr      in  IF/ID instruction (J/JAL index field)
//   id_pc_plus4   in  IF/ID PC+4 (J/JAL region bits)
//   branch_taken  in  ID-stage branch resolved taken
//   branch_target in  ID-stage branch target
//   jump          in  decoder jump select
//   jr_target     in  forwarded rs for JR/JALR
//   pc_plus4      out sequential PC (wraps modulo 2^32)
//   redirect      out a qualified redirect is requested
//   next_pc       out redirect target, or pc_plus4 when not redirecting
//   misaligned    out redirect target has a non-zero byte offset
module npc_sel
    import if_stage_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [1:0]  jump,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_plus4,
    output logic        redirect,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] target;
    logic        req;

    assign pc_plus4 = pc + 32'd4;

    // Priority: branch, then J/JAL, then JR/JALR. The reserved encoding
    // 2'b11 falls through as "no jump".
    always_comb begin
        req    = 1'b0;
        target = pc_plus4;
        if (branch_taken) begin
            req    = 1'b1;
            target = branch_target;
        end else if (jump == JUMP_J) begin
            req    = 1'b1;
            target = j_target(id_pc_plus4, id_instr);
        end else if (jump == JUMP_JR) begin
            req    = 1'b1;
            target = jr_target;
        end
    end

    // A bubble in ID carries no control intent, so it never redirects.
    assign redirect   = req & id_valid;
    assign next_pc    = redirect ? target : pc_plus4;
    assign misaligned = redirect & (target[1:0] != 2'b00);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register feeding the decoder. No branch delay slot; every taken
// redirect inserts exactly one bubble.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   stall          freezes PC and IF/ID (wins over redirect)
//   branch_taken   ID-stage branch taken, branch_target its target
//   jump           00 none, 01 J/JAL, 10 JR/JALR, 11 treated as none
//   jr_target      forwarded rs for JR/JALR
//   imem_addr      instruction-memory address (always equals pc)
//   imem_rdata     instruction at imem_addr, same cycle
//   pc             current fetch PC
//   id_instr, id_pc, id_pc_plus4, id_valid   IF/ID register contents
//   align_err      sticky: some redirect target was not word aligned
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC_P  = RESET_PC,
    parameter logic [31:0] NOP_INSTR_P = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [1:0]  jump,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic        align_err
);

    logic [31:0] pc_reg;
    logic [31:0] id_instr_reg;
    logic [31:0] id_pc_reg;
    logic [31:0] id_pc_plus4_reg;
    logic        id_valid_reg;
    logic        align_err_reg;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        redirect;
    logic        misaligned;

    npc_sel u_npc_sel (
        .pc            (pc_reg),
        .id_valid      (id_valid_reg),
        .id_instr      (id_instr_reg),
        .id_pc_plus4   (id_pc_plus4_reg),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jr_target     (jr_target),
        .pc_plus4      (pc_plus4),
        .redirect      (redirect),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg          <= RESET_PC_P;
            id_instr_reg    <= NOP_INSTR_P;
            id_pc_reg       <= 32'd0;
            id_pc_plus4_reg <= 32'd0;
            id_valid_reg    <= 1'b0;
            align_err_reg   <= 1'b0;
        end else if (!stall) begin
            // A stalled redirect is held in ID by the hazard unit and
            // re-presents later, so nothing (including align_err) moves here.
            pc_reg <= next_pc;
            if (redirect) begin
                // Discard the wrong-path fetch; id_pc/id_pc_plus4 keep their
                // values so a bubble never looks like a new instruction.
                id_instr_reg <= NOP_INSTR_P;
                id_valid_reg <= 1'b0;
                if (misaligned) begin
                    align_err_reg <= 1'b1;
                end
            end else begin
                id_instr_reg    <= imem_rdata;
                id_pc_reg       <= pc_reg;
                id_pc_plus4_reg <= pc_plus4;
                id_valid_reg    <= 1'b1;
            end
        end
    end

    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign id_instr    = id_instr_reg;
    assign id_pc       = id_pc_reg;
    assign id_pc_plus4 = id_pc_plus4_reg;
    assign id_valid    = id_valid_reg;
    assign align_err   = align_err_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, stall, branch, J, JR/alignment,
// reserved jump, priority, PC wrap and asynchronous reset mid-redirect.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [1:0]  jump;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic        align_err;

    int vec_count;
    int err_count;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jr_target     (jr_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4),
        .id_valid      (id_valid),
        .align_err     (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: two fixed words, everything else a pattern tied
    // to the address so each fetch is distinguishable.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2408_0005;
        if (a == 32'h0000_3010) return 32'h0800_0C20;
        return 32'h3C00_0000 ^ a;
    endfunction

    always_comb imem_rdata = imem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pc"},       pc,                 32'h0000_3000);
        chk({tag, ".instr"},    id_instr,           32'h0);
        chk({tag, ".id_pc"},    id_pc,              32'h0);
        chk({tag, ".pc4"},      id_pc_plus4,        32'h0);
        chk({tag, ".valid"},    {31'd0, id_valid},  32'h0);
        chk({tag, ".align"},    {31'd0, align_err}, 32'h0);
    endtask

    initial begin
        vec_count     = 0;
        err_count     = 0;
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 2'b00;
        jr_target     = 32'h0;

        // Reset state, then first fetch
        step();
        chk_reset_vals("rst");
        chk("imem_addr", imem_addr, 32'h0000_3000);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("f1.pc",    pc,                32'h0000_3004);
        chk("f1.instr", id_instr,          32'h2408_0005);
        chk("f1.id_pc", id_pc,             32'h0000_3000);
        chk("f1.pc4",   id_pc_plus4,       32'h0000_3004);
        chk("f1.valid", {31'd0, id_valid}, 32'h1);
        step();
        chk("f2.pc", pc, 32'h0000_3008);

        // Stall three cycles at pc=0x3008
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.pc",    pc,       32'h0000_3008);
            chk("stall.instr", id_instr, 32'h3C00_3004);
            chk("stall.id_pc", id_pc,    32'h0000_3004);
        end
        stall = 1'b0;
        step();
        chk("resume.id_pc", id_pc, 32'h0000_3008);
        chk("resume.pc",    pc,    32'h0000_300C);
        step();
        step();
        chk("pre_br.id_pc", id_pc, 32'h0000_3010);

        // Branch taken from id_pc=0x3010
        branch_taken  = 1'b1;
        branch_target = 32'h0000_3040;
        step();
        chk("br.pc",    pc,                32'h0000_3040);
        chk("br.valid", {31'd0, id_valid}, 32'h0);
        chk("br.instr", id_instr,          32'h0);
        chk("br.id_pc", id_pc,             32'h0000_3010);
        // Bubble in ID must not redirect even with branch_taken still high
        branch_target = 32'h0000_5000;
        step();
        chk("bub.pc",    pc,                32'h0000_3044);
        chk("bub.id_pc", id_pc,             32'h0000_3040);
        chk("bub.valid", {31'd0, id_valid}, 32'h1);

        // Asynchronous reset while a redirect is requested (valid in ID)
        branch_target = 32'h0000_6000;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("arst");
        #1;
        rst          = 1'b0;
        branch_taken = 1'b0;

        // Refill to J at 0x3010
        for (int i = 0; i < 5; i++) step();
        chk("j.id_instr", id_instr,    32'h0800_0C20);
        chk("j.pc4",      id_pc_plus4, 32'h0000_3014);
        jump = 2'b01;
        step();
        chk("j.pc",    pc,                32'h0000_3080);
        chk("j.valid", {31'd0, id_valid}, 32'h0);
        jump = 2'b00;
        step();
        chk("j2.id_pc", id_pc,             32'h0000_3080);
        chk("j2.pc",    pc,                32'h0000_3084);
        chk("j2.valid", {31'd0, id_valid}, 32'h1);

        // JR to misaligned target: first stalled, then released
        jump      = 2'b10;
        jr_target = 32'h0000_3002;
        stall     = 1'b1;
        step();
        chk("jrs.pc",    pc,                 32'h0000_3084);
        chk("jrs.align", {31'd0, align_err}, 32'h0);
        stall = 1'b0;
        step();
        chk("jr.pc",    pc,                 32'h0000_3002);
        chk("jr.align", {31'd0, align_err}, 32'h1);
        jump = 2'b00;
        step();
        chk("jr2.pc",    pc,                 32'h0000_3006);
        chk("jr2.id_pc", id_pc,              32'h0000_3002);
        chk("jr2.align", {31'd0, align_err}, 32'h1);

        // Reserved jump encoding acts as no jump
        jump = 2'b11;
        step();
        chk("j11.pc",    pc,                32'h0000_300A);
        chk("j11.valid", {31'd0, id_valid}, 32'h1);

        // Branch beats JR
        jump          = 2'b10;
        jr_target     = 32'h0000_5000;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_4000;
        step();
        chk("prio.pc", pc, 32'h0000_4000);
        branch_taken = 1'b0;
        jump         = 2'b00;
        step();

        // PC+4 wraps to zero
        jump      = 2'b10;
        jr_target = 32'hFFFF_FFFC;
        step();
        chk("wrap0.pc", pc, 32'hFFFF_FFFC);
        jump = 2'b00;
        step();
        chk("wrap.pc",    pc,          32'h0000_0000);
        chk("wrap.id_pc", id_pc,       32'hFFFF_FFFC);
        chk("wrap.pc4",   id_pc_plus4, 32'h0000_0000);
        chk("wrap.addr",  imem_addr,   32'h0000_0000);
        chk("wrap.align", {31'd0, align_err}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the ID-stage control decoder.
- Owns the PC register and next-PC selection: sequential, branch, J/JAL, and JR/JALR targets.
- Drives the instruction-memory address and holds the IF/ID pipeline register whose id_instr feeds the decoder.
- Implements stall hold and redirect bubbles. There is no branch delay slot.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble encoding (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  from hazard unit; freezes PC and IF/ID.
- branch_taken  in  1  ID-stage branch resolved taken.
- branch_target  in  32  ID-stage branch target.
- jump  in  2  decoder Jump: 00 none, 01 J/JAL, 10 JR/JALR, 11 reserved.
- jr_target  in  32  forwarded rs value for JR/JALR.
- imem_addr  out  32  equals pc; combinational-read instruction memory.
- imem_rdata  in  32  instruction at imem_addr, same cycle.
- pc  out  32  current fetch PC.
- id_instr  out  32  IF/ID instruction, to the decoder.
- id_pc  out  32  IF/ID PC.
- id_pc_plus4  out  32  IF/ID PC+4, used by JAL/JALR link and J target.
- id_valid  out  1  IF/ID holds a real instruction.
- align_err  out  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
Reset:
- rst asserted at any time, including mid-stall or mid-redirect, immediately forces: pc=RESET_PC, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0, id_valid=0, align_err=0.

Latency:
- An instruction fetched at pc in cycle n appears on id_instr in cycle n+1.
- The first valid id_instr appears on the first clock edge after rst deasserts.

Redirect:
- redirect = branch_taken | (jump==01) | (jump==10).
- Target priority: branch_taken → branch_target; else jump==01 → {id_pc_plus4[31:28], id_instr[25:0], 2'b00}; else jump==10 → jr_target.
- jump==11 is treated as no jump.
- All arithmetic is modulo 2^32; PC+4 wraps from 32'hFFFF_FFFC to 0.

Per rising edge, when not in reset, in this priority order:
- stall=1: pc and every IF/ID field hold. stall wins over redirect; the hazard unit keeps the redirecting instruction in ID, so the redirect re-presents in a later cycle.
- redirect=1: pc <= target. IF/ID <= bubble (id_instr=NOP_INSTR, id_valid=0, id_pc and id_pc_plus4 hold). The wrong-path instruction is discarded, so each taken redirect costs exactly one bubble.
- otherwise: pc <= pc+4; id_instr <= imem_rdata; id_pc <= pc; id_pc_plus4 <= pc+4; id_valid <= 1.

Alignment:
- A redirect whose target has [1:0] != 0 still loads pc with the full target unmodified.
- It sets align_err, which stays set until reset.

Invariants:
- Redirect inputs are qualified internally by id_valid; a bubble in ID never redirects.
- imem_addr is always equal to pc.

Decomposition:
- Shared pipeline package holds: JUMP_NONE/JUMP_J/JUMP_JR (2-bit encodings matching the decoder), NOP_INSTR, RESET_PC.
- Sub-module npc_sel: purely combinational next-PC mux and alignment check.
- if_stage contains the PC register and IF/ID register.

Test Plan:
- Reset: rst high then released, imem returns 32'h2408_0005 at 0x3000 → after one edge pc=0x3004, id_instr=32'h2408_0005, id_pc=0x3000, id_valid=1.
- Stall: stall=1 for 3 cycles with pc=0x3008 → pc, id_instr and id_pc are unchanged for those 3 cycles; sequential fetch resumes at 0x3008 when stall=0.
- Branch: branch_taken=1 with branch_target=0x3040 while id_pc=0x3010 → next cycle pc=0x3040, id_valid=0, id_instr=0; the cycle after, id_pc=0x3040.
- J: id_instr=32'h0800_0C20 (j to 0x3080), id_pc_plus4=0x3014, jump=01 → pc=0x0000_3080 and a single bubble.
- JR priority and alignment: jump=10, jr_target=0x3002 with branch_taken=0 → pc=0x3002 and align_err=1, and align_err stays set. Repeat with stall=1 → no change.
- Async reset mid-redirect: rst pulsed between edges while branch_taken=1 → outputs take reset values immediately, with no clock edge required.
